// File: rtl/div_sequencer.sv
// Multi-cycle RV64M divide/remainder sequencer beside the EX-stage ALU.
// Radix-2 restoring divider with sign fixup and 32-bit result adjustment.
module div_sequencer #(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      inStart,
  input  logic [5:0]                inAluControl,
  input  logic [BUS_DATA_WIDTH-1:0] inData1,
  input  logic [BUS_DATA_WIDTH-1:0] inData2,
  input  logic [4:0]                inDestRegister,
  input  logic                      inFlush,
  input  logic                      inStallFromCache,
  output logic                      outStall,
  output logic                      outValid,
  output logic [BUS_DATA_WIDTH-1:0] outResult,
  output logic [4:0]                outDestRegister
);
  localparam int W  = BUS_DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;
  state_t state, state_nx;

  logic          legal, op_sgn, op_rem, op_w;
  logic [W-1:0]  a_ext, b_ext, a_abs, b_abs, min_val;
  logic [W-1:0]  sp_q, sp_r;
  logic          a_neg, b_neg, div0, ovf, special, accept;
  logic [CW-1:0] cnt;
  logic [W-1:0]  quo, rem, dvs, res_fix;
  logic          neg_q, neg_r, sel_rem, sel_w;
  logic [W:0]    shl, trial;

  // Sign-extend the low word for 32-bit ops.
  function automatic logic [W-1:0] wfix(input logic w, input logic [W-1:0] v);
    return w ? {{(W-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Opcode decode into signed / remainder / word flags.
  always_comb begin
    legal  = 1'b1;
    op_sgn = 1'b0;
    op_rem = 1'b0;
    op_w   = 1'b0;
    unique case (inAluControl)
      6'b100011: op_sgn = 1'b1;
      6'b100100: begin end
      6'b100101: begin op_sgn = 1'b1; op_rem = 1'b1; end
      6'b100110: op_rem = 1'b1;
      6'b101000: begin op_sgn = 1'b1; op_w = 1'b1; end
      6'b101001: op_w = 1'b1;
      6'b101010: begin op_sgn = 1'b1; op_rem = 1'b1; op_w = 1'b1; end
      6'b101011: begin op_rem = 1'b1; op_w = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end

  // Operand width adjust, magnitudes and special-case results.
  always_comb begin
    if (op_w) begin
      a_ext = {{(W-32){op_sgn & inData1[31]}}, inData1[31:0]};
      b_ext = {{(W-32){op_sgn & inData2[31]}}, inData2[31:0]};
    end else begin
      a_ext = inData1;
      b_ext = inData2;
    end
    a_neg   = op_sgn & a_ext[W-1];
    b_neg   = op_sgn & b_ext[W-1];
    a_abs   = a_neg ? -a_ext : a_ext;
    b_abs   = b_neg ? -b_ext : b_ext;
    min_val = op_w ? {{(W-31){1'b1}}, 31'b0} : {1'b1, {(W-1){1'b0}}};
    div0    = (b_ext == '0);
    ovf     = op_sgn & (a_ext == min_val) & (b_ext == '1);
    special = div0 | ovf;
    sp_q    = div0 ? '1 : a_ext;
    sp_r    = div0 ? a_ext : '0;
    accept  = reset_n & (state == IDLE) & inStart & legal
            & ~inFlush & ~inStallFromCache;
  end

  // Trial subtraction and sign-corrected result.
  always_comb begin
    shl     = {rem, quo[W-1]};
    trial   = shl - {1'b0, dvs};
    res_fix = sel_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state: flush wins, cache stall freezes.
  always_comb begin
    state_nx = state;
    if (inFlush) begin
      state_nx = IDLE;
    end else if (!inStallFromCache) begin
      unique case (state)
        IDLE:    if (accept) state_nx = special ? DONE : BUSY;
        BUSY:    if (cnt == CW'(1)) state_nx = FIXUP;
        FIXUP:   state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Pipeline stall and result-valid outputs.
  always_comb begin
    outStall = reset_n & (accept | (state == BUSY) | (state == FIXUP));
    outValid = (state == DONE);
  end

  // Operand capture, divide iterations and result register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt             <= '0;
      quo             <= '0;
      rem             <= '0;
      dvs             <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      sel_rem         <= 1'b0;
      sel_w           <= 1'b0;
      outResult       <= '0;
      outDestRegister <= '0;
    end else if (!inFlush && !inStallFromCache) begin
      unique case (state)
        IDLE: if (accept) begin
          outDestRegister <= inDestRegister;
          sel_rem <= op_rem;
          sel_w   <= op_w;
          neg_q   <= a_neg ^ b_neg;
          neg_r   <= a_neg;
          quo     <= op_w ? (a_abs << 32) : a_abs;
          rem     <= '0;
          dvs     <= b_abs;
          cnt     <= op_w ? CW'(32) : CW'(W);
          if (special) outResult <= wfix(op_w, op_rem ? sp_r : sp_q);
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (trial[W]) begin
            rem <= shl[W-1:0];
            quo <= {quo[W-2:0], 1'b0};
          end else begin
            rem <= trial[W-1:0];
            quo <= {quo[W-2:0], 1'b1};
          end
        end
        FIXUP:   outResult <= wfix(sel_w, res_fix);
        default: begin end
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer against an arithmetic reference model.
// Per-cycle compare of stall/valid/result/rd with literal pins on the model.
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        reset_n, inStart, inFlush, inStallFromCache;
  logic [5:0]  inAluControl;
  logic [63:0] inData1, inData2;
  logic [4:0]  inDestRegister;
  logic        outStall, outValid;
  logic [63:0] outResult;
  logic [4:0]  outDestRegister;

  localparam logic [5:0] DIV   = 6'b100011;
  localparam logic [5:0] DIVU  = 6'b100100;
  localparam logic [5:0] REM   = 6'b100101;
  localparam logic [5:0] REMU  = 6'b100110;
  localparam logic [5:0] DIVW  = 6'b101000;
  localparam logic [5:0] DIVUW = 6'b101001;
  localparam logic [5:0] REMW  = 6'b101010;
  localparam logic [5:0] REMUW = 6'b101011;

  int          checks = 0, errors = 0;
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_valid, chk_res, chk_rd;
  logic [63:0] exp_res;
  logic [4:0]  exp_rd;
  int          cur_cyc, first_valid;
  string       cur_nm;
  logic [63:0] last_res = '0;

  always #5 clk = ~clk;

  div_sequencer #(.BUS_DATA_WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n), .inStart(inStart),
    .inAluControl(inAluControl), .inData1(inData1), .inData2(inData2),
    .inDestRegister(inDestRegister), .inFlush(inFlush),
    .inStallFromCache(inStallFromCache), .outStall(outStall),
    .outValid(outValid), .outResult(outResult),
    .outDestRegister(outDestRegister)
  );

  task automatic chk(input string nm, input logic [63:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic bit is_w(input logic [5:0] op);
    return op inside {DIVW, DIVUW, REMW, REMUW};
  endfunction

  // RISC-V divide semantics with plain arithmetic.
  function automatic logic [63:0] model(input logic [5:0] op,
      input logic [63:0] a, b, output bit sp);
    bit s, r, w;
    logic [63:0] q, m, ua, ub;
    longint sa, sb, mn;
    s = op inside {DIV, REM, DIVW, REMW};
    r = op inside {REM, REMU, REMW, REMUW};
    w = is_w(op);
    if (w) begin
      sa = longint'($signed(a[31:0]));
      sb = longint'($signed(b[31:0]));
      ua = {32'd0, a[31:0]};
      ub = {32'd0, b[31:0]};
      mn = 64'shFFFF_FFFF_8000_0000;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      mn = 64'sh8000_0000_0000_0000;
    end
    sp = 1'b0;
    if (s) begin
      if (sb == 0) begin
        q = '1; m = sa; sp = 1'b1;
      end else if (sb == -1 && sa == mn) begin
        q = sa; m = '0; sp = 1'b1;
      end else begin
        q = sa / sb; m = sa % sb;
      end
    end else begin
      if (ub == 0) begin
        q = '1; m = ua; sp = 1'b1;
      end else begin
        q = ua / ub; m = ua % ub;
      end
    end
    q = r ? m : q;
    return w ? {{32{q[31]}}, q[31:0]} : q;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk($sformatf("%s stall c%0d", cur_nm, cur_cyc), 64'(outStall), 64'(exp_stall));
      chk($sformatf("%s valid c%0d", cur_nm, cur_cyc), 64'(outValid), 64'(exp_valid));
      if (outValid === 1'b1 && first_valid < 0) first_valid = cur_cyc;
      if (chk_res)
        chk($sformatf("%s result c%0d", cur_nm, cur_cyc), outResult, exp_res);
      if (chk_rd)
        chk($sformatf("%s rd c%0d", cur_nm, cur_cyc), 64'(outDestRegister), 64'(exp_rd));
    end
  end

  // One op; -1 disables st_at/fl_at/rs_at; lit_cyc -1 means never valid.
  task automatic run_op(input string nm, input logic [5:0] op,
      input logic [63:0] a, b, input logic [4:0] rd,
      input logic [63:0] lit, input int lit_cyc,
      input int st_at, st_len, fl_at, rs_at);
    int lat, cnt, c, cb, ab;
    bit sp, legal, stl, rst_ab, done;
    logic [63:0] mres;
    cur_nm = nm;
    legal  = (op inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW});
    mres   = model(op, a, b, sp);
    if (legal) chk({nm, " model"}, mres, lit);
    lat = sp ? 1 : (is_w(op) ? 34 : 66);
    cnt = 0; c = 0; ab = -1; rst_ab = 1'b0; done = 1'b0;
    first_valid = -1;
    while (!done) begin
      @(posedge clk); #1;
      cur_cyc = c;
      cb  = cnt;
      stl = (st_at >= 0) && (c >= st_at) && (c < st_at + st_len);
      inStart          = (c == 0);
      inAluControl     = op;
      inData1          = a;
      inData2          = b;
      inDestRegister   = rd;
      inFlush          = (c == fl_at);
      inStallFromCache = stl;
      reset_n          = (c != rs_at);
      chk_res = 1'b0; chk_rd = 1'b0;
      exp_res = mres; exp_rd = rd;
      if (!legal || (ab >= 0 && c > ab) || c == rs_at || (c == 0 && fl_at == 0)) begin
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        if (ab >= 0 && c > ab) begin
          chk_res = 1'b1;
          exp_res = rst_ab ? 64'd0 : last_res;
          chk_rd  = rst_ab;
          exp_rd  = 5'd0;
        end
      end else begin
        exp_stall = (cb < lat);
        exp_valid = (cb == lat);
        chk_res   = exp_valid;
        chk_rd    = exp_valid;
      end
      chk_en = 1'b1;
      if (ab < 0 && (c == fl_at || c == rs_at)) begin
        ab = c;
        rst_ab = (c == rs_at);
      end
      if (!stl) cnt++;
      if (!legal)       done = (c >= 2);
      else if (ab >= 0) done = (c >= ab + 1);
      else              done = (cb == lat + 1);
      c++;
      if (c > 400) begin
        errors++;
        $display("FAIL %s timeout", nm);
        done = 1'b1;
      end
    end
    @(negedge clk); #1;
    chk_en = 1'b0;
    inStart = 1'b0; inFlush = 1'b0; inStallFromCache = 1'b0; reset_n = 1'b1;
    chk({nm, " first_valid"}, 64'(first_valid), 64'(lit_cyc));
    if (rst_ab) last_res = '0;
    else if (legal && ab < 0) last_res = mres;
  endtask

  initial begin
    reset_n = 1'b0; inStart = 1'b0; inFlush = 1'b0; inStallFromCache = 1'b0;
    inAluControl = '0; inData1 = '0; inData2 = '0; inDestRegister = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", 64'(outStall), 64'd0);
    chk("reset valid", 64'(outValid), 64'd0);
    chk("reset result", outResult, 64'd0);
    chk("reset rd", 64'(outDestRegister), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    run_op("div_100_m7", DIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd5,
           64'hFFFF_FFFF_FFFF_FFF2, 66, -1, 0, -1, -1);
    run_op("rem_m100_7", REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd6,
           64'hFFFF_FFFF_FFFF_FFFE, 66, -1, 0, -1, -1);
    run_op("remu_max_10", REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 5'd7,
           64'd5, 66, -1, 0, -1, -1);
    run_op("divu_max_2", DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8,
           64'h7FFF_FFFF_FFFF_FFFF, 66, -1, 0, -1, -1);
    run_op("divu_by0", DIVU, 64'd5, 64'd0, 5'd9,
           64'hFFFF_FFFF_FFFF_FFFF, 1, -1, 0, -1, -1);
    run_op("rem_by0", REM, 64'd5, 64'd0, 5'd10,
           64'd5, 1, -1, 0, -1, -1);
    run_op("div_ovf", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
           64'h8000_0000_0000_0000, 1, -1, 0, -1, -1);
    run_op("rem_ovf", REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
           64'd0, 1, -1, 0, -1, -1);
    run_op("divw_ovf", DIVW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13,
           64'hFFFF_FFFF_8000_0000, 1, -1, 0, -1, -1);
    run_op("divuw_max_1", DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd14,
           64'hFFFF_FFFF_FFFF_FFFF, 34, -1, 0, -1, -1);
    run_op("remw_garbage", REMW, 64'hDEAD_BEEF_0000_0007, 64'd2, 5'd15,
           64'd1, 34, -1, 0, -1, -1);
    run_op("div_busy_stall", DIV, 64'd1000, 64'd3, 5'd16,
           64'h14D, 71, 20, 5, -1, -1);
    run_op("rem_done_stall", REM, 64'd1000, 64'd3, 5'd17,
           64'd1, 66, 66, 3, -1, -1);
    run_op("div_flush10", DIV, 64'd77, 64'd5, 5'd18,
           64'd15, -1, -1, 0, 10, -1);
    run_op("divw_after_flush", DIVW, 64'h0000_0000_FFFF_FFEC, 64'd6, 5'd19,
           64'hFFFF_FFFF_FFFF_FFFD, 34, -1, 0, -1, -1);
    run_op("divu_flush_accept", DIVU, 64'd9, 64'd2, 5'd20,
           64'd4, -1, -1, 0, 0, -1);
    run_op("div_reset20", DIV, 64'd50, 64'd7, 5'd21,
           64'd7, -1, -1, 0, -1, 20);
    run_op("remuw_hi", REMUW, 64'h0000_0001_0000_000D, 64'd4, 5'd22,
           64'd1, 34, -1, 0, -1, -1);
    run_op("divuw_sext", DIVUW, 64'h0000_0000_8000_0000, 64'd1, 5'd23,
           64'hFFFF_FFFF_8000_0000, 34, -1, 0, -1, -1);
    run_op("illegal", 6'b100000, 64'd8, 64'd2, 5'd24,
           64'd0, -1, -1, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
